// File: rtl/pwm_ramp_ctrl_if.sv
// Command handshake bundle between the register-file command path and the PWMH ramp controller.
// The master issues target/step/hold requests; the slave reports readiness.
interface pwm_ramp_ctrl_if #(
    parameter int W      = 16,
    parameter int HOLD_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [W-1:0]      cmd_target;
    logic [W-1:0]      cmd_step;
    logic [HOLD_W-1:0] cmd_hold;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_step,
        output cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_step,
        input  cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Ramps one PWM channel's high-time toward a commanded target in bounded steps,
// advancing one step every (hold+1) PWM period wraps.
module pwm_ramp_ctrl #(
    parameter int          W      = 16,
    parameter int          HOLD_W = 8,
    parameter int unsigned INIT_H = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           period_tick,
    input  logic           abort,
    pwm_ramp_ctrl_if.slave cmd,
    output logic [W-1:0]   pwmh_out,
    output logic           busy,
    output logic           done,
    output logic           aborted
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t            state, state_next;
    logic [W-1:0]      target_q, target_next;
    logic [W-1:0]      step_q, step_next;
    logic [HOLD_W-1:0] hold_q, hold_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic [W-1:0]      pwmh_next;
    logic              done_next;
    logic              aborted_next;

    logic              going_up;
    logic [W-1:0]      diff;
    logic              reach;
    logic [W-1:0]      stepped;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pwmh_out <= W'(INIT_H);
            target_q <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state    <= state_next;
            pwmh_out <= pwmh_next;
            target_q <= target_next;
            step_q   <= step_next;
            hold_q   <= hold_next;
            hold_cnt <= hold_cnt_next;
            done     <= done_next;
            aborted  <= aborted_next;
        end
    end

    // Clamp to the target whenever the remaining distance fits in one step, so it never overshoots.
    always_comb begin
        going_up = (target_q > pwmh_out);
        diff     = going_up ? (target_q - pwmh_out) : (pwmh_out - target_q);
        reach    = (step_q == '0) || (diff <= step_q);
        if (reach)
            stepped = target_q;
        else if (going_up)
            stepped = pwmh_out + step_q;
        else
            stepped = pwmh_out - step_q;
    end

    always_comb begin
        state_next    = state;
        pwmh_next     = pwmh_out;
        target_next   = target_q;
        step_next     = step_q;
        hold_next     = hold_q;
        hold_cnt_next = hold_cnt;
        done_next     = 1'b0;
        aborted_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    target_next   = cmd.cmd_target;
                    step_next     = cmd.cmd_step;
                    hold_next     = cmd.cmd_hold;
                    hold_cnt_next = '0;
                    if (cmd.cmd_target == pwmh_out)
                        done_next = 1'b1;
                    else
                        state_next = RAMP;
                end
            end
            RAMP: begin
                // Abort wins over a coincident tick: the output freezes at its present value.
                if (abort) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                    aborted_next  = 1'b1;
                end else if (period_tick) begin
                    if (hold_cnt == hold_q) begin
                        pwmh_next     = stepped;
                        hold_cnt_next = '0;
                        if (reach) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        hold_cnt_next = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state == IDLE);
        busy          = (state == RAMP);
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequences the high-time (PWMH) value fed to one PWM channel.
- Moves the value from its current level to a commanded target in bounded steps, one step every N+1 PWM periods. This gives soft-start/soft-stop ramps for motor and servo outputs.
- Sits between the register-file command path and the PWM generator's PWMH input.
- Uses the generator's period-wrap pulse as its time base.

Parameters:
- W, 16, width of high-time, target and step values
- HOLD_W, 8, width of the hold (periods-per-step) field
- INIT_H, 0, reset value of pwmh_out

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- period_tick  input  1  one-cycle pulse when the PWM period counter wraps to 0
- cmd_valid  input  1  command request
- cmd_ready  output  1  command can be accepted; combinational, high iff state==IDLE
- cmd_target  input  W  final high-time
- cmd_step  input  W  max change per step; 0 = jump directly to target
- cmd_hold  input  HOLD_W  extra periods between steps (0 = step every tick)
- abort  input  1  stop ramp, freeze output
- pwmh_out  output  W  high-time driven to PWM generator (registered)
- busy  output  1  high iff state==RAMP
- done  output  1  one-cycle pulse: target reached
- aborted  output  1  one-cycle pulse: ramp abandoned by abort

Behaviour:
- Reset (async, any state, including mid-ramp):
  - pwmh_out=INIT_H, state=IDLE, hold_cnt=0.
  - done=0, aborted=0, busy=0, cmd_ready=1.
- States are IDLE and RAMP.
- done and aborted default to 0 every cycle; they are only set for one cycle as described below.
- IDLE:
  - Accept occurs on a clock edge where cmd_valid && cmd_ready.
  - On accept, latch target, step and hold into internal registers, and set hold_cnt=0.
  - If cmd_target==pwmh_out: stay IDLE and pulse done on the next cycle. No tick is required.
  - Otherwise: go to RAMP.
  - abort in IDLE is ignored. A command with abort high in IDLE is still accepted.
- RAMP:
  - cmd_ready=0; incoming commands are not accepted and not queued.
  - On a period_tick cycle with abort low:
    - if hold_cnt==hold, apply one step and set hold_cnt=0;
    - else hold_cnt+=1.
  - Cycles without period_tick change nothing.
- Step arithmetic (unsigned, on the registered value):
  - Upward (target>cur): diff=target-cur. If step==0 or diff<=step, then cur<=target; else cur<=cur+step.
  - Downward: symmetric with diff=cur-target and cur<=cur-step.
  - No overflow or underflow is possible; the step never overshoots the target.
- Completion:
  - The step that makes pwmh_out==target also sets state<=IDLE and done<=1 on the same edge.
  - done is therefore high in the first cycle that shows the final value, and cmd_ready is high in that same cycle.
  - A back-to-back command may be accepted during the done cycle.
- Latency: pwmh_out updates on the clock edge that samples the qualifying period_tick, so the new value is visible the cycle after the tick.
- Abort in RAMP:
  - On the edge, pwmh_out holds its current value, state<=IDLE, hold_cnt=0, aborted<=1, no done.
  - Abort takes priority over a simultaneous period_tick; no step is applied in that cycle.
- Step count: with step s>0, |diff|=d and hold h, the ramp completes after ceil(d/s)*(h+1) ticks.
- pwmh_out changes only on a step, on accept-free reset, or on reset. It never changes in IDLE except via reset.

Test Plan:
- Reset mid-ramp (pwmh_out=300) -> pwmh_out=0, busy=0, cmd_ready=1, done=0 immediately, without waiting for a clock edge.
- From 0, cmd target=100 step=30 hold=0, then 4 ticks:
  - pwmh_out goes 30,60,90,100, each visible the cycle after its tick;
  - done pulses once with pwmh_out=100;
  - busy falls in the same cycle.
- From 100, target=40 step=25 hold=2:
  - pwmh_out changes on ticks 3, 6 and 9 to 75, 50, 40;
  - ticks 1, 2, 4, 5, 7 and 8 leave it unchanged;
  - done follows the 9th tick.
- From 40, target=40 step=5 -> accepted with no ticks; done pulses the next cycle; busy never rises.
- Ramp 0->1000 step=100 hold=0, abort asserted together with the 3rd tick:
  - pwmh_out stays 200; aborted pulses; done never fires; cmd_ready returns to 1.
- step=0, target=0xFFFF from 0 -> single tick gives pwmh_out=0xFFFF with done. A cmd_valid held during RAMP is not accepted until the done cycle, then it is accepted.
